// File: rtl/v30mz_pkg.sv
// rtl/v30mz_pkg.sv - shared constants, FSM states and field bundle for the instruction collector
// Contents: prefix byte values, segment register indices, REP encodings,
//           collector FSM state enum, instr_fields_t output bundle,
//           disp_size_of() helper that sizes the displacement from a ModRM byte.
package v30mz_pkg;

  localparam logic [7:0] PFX_SEG_DS1 = 8'h26;
  localparam logic [7:0] PFX_SEG_PS  = 8'h2E;
  localparam logic [7:0] PFX_SEG_SS  = 8'h36;
  localparam logic [7:0] PFX_SEG_DS0 = 8'h3E;
  localparam logic [7:0] PFX_LOCK    = 8'hF0;
  localparam logic [7:0] PFX_REPNE   = 8'hF2;
  localparam logic [7:0] PFX_REP     = 8'hF3;

  localparam logic [1:0] SEG_PS  = 2'd0;
  localparam logic [1:0] SEG_SS  = 2'd1;
  localparam logic [1:0] SEG_DS0 = 2'd2;
  localparam logic [1:0] SEG_DS1 = 2'd3;

  localparam logic [1:0] REP_NONE = 2'd0;
  localparam logic [1:0] REP_NE   = 2'd2;
  localparam logic [1:0] REP_E    = 2'd3;

  typedef enum logic [2:0] {
    ST_OPCODE,
    ST_MODRM,
    ST_DISP,
    ST_IMM,
    ST_DONE
  } collect_state_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic        has_modrm;
    logic [7:0]  modrm;
    logic [15:0] disp;
    logic [1:0]  disp_size;
    logic [31:0] imm;
    logic [2:0]  imm_size;
    logic        seg_override_valid;
    logic [1:0]  seg_override;
    logic [1:0]  rep_prefix;
    logic        lock_prefix;
  } instr_fields_t;

  // mod=11 is a register operand; mod=00/rm=110 is the direct 16-bit address form.
  function automatic logic [1:0] disp_size_of(input logic [7:0] modrm);
    case (modrm[7:6])
      2'b01:   return 2'd1;
      2'b10:   return 2'd2;
      2'b00:   return (modrm[2:0] == 3'b110) ? 2'd2 : 2'd0;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// rtl/opcode_classifier.sv - combinational opcode table: prefix flag, ModRM need, immediate size
// Ports:
//   opcode      in  8  byte being classified
//   modrm_reg   in  3  ModRM reg field (only meaningful when modrm_valid)
//   modrm_valid in  1  modrm_reg is a real ModRM reg field
//   is_prefix   out 1  byte is a segment/LOCK/REP prefix
//   need_modrm  out 1  opcode is followed by a ModRM byte
//   imm_size    out 3  immediate bytes following ModRM/displacement (0..4)
module opcode_classifier
  import v30mz_pkg::*;
(
  input  logic [7:0] opcode,
  input  logic [2:0] modrm_reg,
  input  logic       modrm_valid,
  output logic       is_prefix,
  output logic       need_modrm,
  output logic [2:0] imm_size
);

  // Anything not listed (including undefined opcodes) is a 1-byte instruction.
  always_comb begin
    is_prefix  = 1'b0;
    need_modrm = 1'b0;
    imm_size   = 3'd0;
    casez (opcode)
      8'b00???0??: need_modrm = 1'b1;                      // ALU r/m forms
      8'b00???100: imm_size = 3'd1;                        // ALU AL,imm8
      8'b00???101: imm_size = 3'd2;                        // ALU AW,imm16
      8'b001??110: is_prefix = 1'b1;                       // 26/2E/36/3E
      8'h62:       need_modrm = 1'b1;                      // BOUND
      8'h68:       imm_size = 3'd2;
      8'h69:       begin need_modrm = 1'b1; imm_size = 3'd2; end
      8'h6A:       imm_size = 3'd1;
      8'h6B:       begin need_modrm = 1'b1; imm_size = 3'd1; end
      8'b0111????: imm_size = 3'd1;                        // Jcc rel8
      8'h80, 8'h82, 8'h83: begin need_modrm = 1'b1; imm_size = 3'd1; end
      8'h81:       begin need_modrm = 1'b1; imm_size = 3'd2; end
      8'b100001??: need_modrm = 1'b1;                      // TEST/XCHG r/m
      8'b10001???: need_modrm = 1'b1;                      // MOV/LEA/POP r/m
      8'h9A:       imm_size = 3'd4;                        // CALL far
      8'b101000??: imm_size = 3'd2;                        // MOV acc,moffs
      8'hA8:       imm_size = 3'd1;
      8'hA9:       imm_size = 3'd2;
      8'b10110???: imm_size = 3'd1;                        // MOV r8,imm8
      8'b10111???: imm_size = 3'd2;                        // MOV r16,imm16
      8'hC0, 8'hC1: begin need_modrm = 1'b1; imm_size = 3'd1; end
      8'hC2, 8'hCA: imm_size = 3'd2;                       // RET imm16
      8'hC4, 8'hC5: need_modrm = 1'b1;
      8'hC6:       begin need_modrm = 1'b1; imm_size = 3'd1; end
      8'hC7:       begin need_modrm = 1'b1; imm_size = 3'd2; end
      8'hC8:       imm_size = 3'd3;                        // ENTER imm16,imm8
      8'hCD:       imm_size = 3'd1;
      8'b110100??: need_modrm = 1'b1;                      // shifts
      8'hD4, 8'hD5: imm_size = 3'd1;
      8'b11011???: need_modrm = 1'b1;                      // coprocessor escape
      8'b11100???: imm_size = 3'd1;                        // LOOP/JCXZ/IN/OUT imm8
      8'hE8, 8'hE9: imm_size = 3'd2;
      8'hEA:       imm_size = 3'd4;                        // JMP far
      8'hEB:       imm_size = 3'd1;
      PFX_LOCK, PFX_REPNE, PFX_REP: is_prefix = 1'b1;
      // Group 3: only TEST (reg=000) carries an immediate.
      8'hF6: begin
        need_modrm = 1'b1;
        imm_size   = (modrm_valid && modrm_reg == 3'b000) ? 3'd1 : 3'd0;
      end
      8'hF7: begin
        need_modrm = 1'b1;
        imm_size   = (modrm_valid && modrm_reg == 3'b000) ? 3'd2 : 3'd0;
      end
      8'hFE, 8'hFF: need_modrm = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/instruction_collector.sv
// rtl/instruction_collector.sv - pops prefetch bytes and assembles one field-split instruction
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   prefetch_data/queue_empty/queue_pop   byte stream from the prefetch queue head
//   flush               discard any partial or pending instruction
//   instr_valid/instr_ready               handshake to the execution unit
//   opcode, has_modrm, modrm, disp, disp_size, imm, imm_size   instruction fields
//   seg_override_valid, seg_override, rep_prefix, lock_prefix prefix state
//   instr_length        bytes consumed including prefixes, saturating
module instruction_collector
  import v30mz_pkg::*;
#(
  parameter int LENGTH_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              prefetch_data,
  input  logic                    queue_empty,
  output logic                    queue_pop,
  input  logic                    flush,
  input  logic                    instr_ready,
  output logic                    instr_valid,
  output logic [7:0]              opcode,
  output logic                    has_modrm,
  output logic [7:0]              modrm,
  output logic [15:0]             disp,
  output logic [1:0]              disp_size,
  output logic [31:0]             imm,
  output logic [2:0]              imm_size,
  output logic                    seg_override_valid,
  output logic [1:0]              seg_override,
  output logic [1:0]              rep_prefix,
  output logic                    lock_prefix,
  output logic [LENGTH_WIDTH-1:0] instr_length
);

  collect_state_t          state, state_next;
  instr_fields_t           fields;
  logic [LENGTH_WIDTH-1:0] length;
  logic [1:0]              byte_cnt;

  logic       cls_is_prefix;
  logic       cls_need_modrm;
  logic [2:0] cls_imm_size;
  logic [7:0] cls_opcode;
  logic [1:0] modrm_disp_size;
  logic       disp_last;
  logic       imm_last;
  logic       clear;

  // In OPCODE the head byte itself is classified; in MODRM the latched opcode
  // is re-classified with the incoming reg field so group 3 gets its immediate.
  assign cls_opcode      = (state == ST_OPCODE) ? prefetch_data : fields.opcode;
  assign modrm_disp_size = disp_size_of(prefetch_data);
  assign disp_last       = (byte_cnt == fields.disp_size - 2'd1);
  assign imm_last        = ({1'b0, byte_cnt} == fields.imm_size - 3'd1);
  assign clear           = reset || flush || (state == ST_DONE && instr_ready);

  opcode_classifier u_classifier (
    .opcode      (cls_opcode),
    .modrm_reg   (prefetch_data[5:3]),
    .modrm_valid (state == ST_MODRM),
    .is_prefix   (cls_is_prefix),
    .need_modrm  (cls_need_modrm),
    .imm_size    (cls_imm_size)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_OPCODE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    instr_valid = 1'b0;
    queue_pop   = (state != ST_DONE) && !queue_empty && !flush && !reset;
    case (state)
      ST_OPCODE: begin
        if (queue_pop && !cls_is_prefix) begin
          if (cls_need_modrm)          state_next = ST_MODRM;
          else if (cls_imm_size != 0)  state_next = ST_IMM;
          else                         state_next = ST_DONE;
        end
      end
      ST_MODRM: begin
        if (queue_pop) begin
          if (modrm_disp_size != 0)    state_next = ST_DISP;
          else if (cls_imm_size != 0)  state_next = ST_IMM;
          else                         state_next = ST_DONE;
        end
      end
      ST_DISP: begin
        if (queue_pop && disp_last) begin
          state_next = (fields.imm_size != 0) ? ST_IMM : ST_DONE;
        end
      end
      ST_IMM: begin
        if (queue_pop && imm_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        instr_valid = 1'b1;
        if (instr_ready) state_next = ST_OPCODE;
      end
      default: state_next = ST_OPCODE;
    endcase
    if (flush) state_next = ST_OPCODE;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      fields   <= '0;
      length   <= '0;
      byte_cnt <= 2'd0;
    end else if (queue_pop) begin
      if (length != '1) length <= length + LENGTH_WIDTH'(1);
      case (state)
        ST_OPCODE: begin
          if (cls_is_prefix) begin
            case (prefetch_data)
              PFX_SEG_PS:  begin fields.seg_override_valid <= 1'b1; fields.seg_override <= SEG_PS;  end
              PFX_SEG_SS:  begin fields.seg_override_valid <= 1'b1; fields.seg_override <= SEG_SS;  end
              PFX_SEG_DS0: begin fields.seg_override_valid <= 1'b1; fields.seg_override <= SEG_DS0; end
              PFX_SEG_DS1: begin fields.seg_override_valid <= 1'b1; fields.seg_override <= SEG_DS1; end
              PFX_LOCK:    fields.lock_prefix <= 1'b1;
              PFX_REPNE:   fields.rep_prefix  <= REP_NE;
              PFX_REP:     fields.rep_prefix  <= REP_E;
              default: ;
            endcase
          end else begin
            fields.opcode    <= prefetch_data;
            fields.has_modrm <= cls_need_modrm;
            fields.imm_size  <= cls_imm_size;
          end
          byte_cnt <= 2'd0;
        end
        ST_MODRM: begin
          fields.modrm     <= prefetch_data;
          fields.disp_size <= modrm_disp_size;
          fields.imm_size  <= cls_imm_size;
          byte_cnt         <= 2'd0;
        end
        ST_DISP: begin
          // The low byte is written sign-extended so a 1-byte displacement is complete.
          if (byte_cnt == 2'd0) fields.disp <= {{8{prefetch_data[7]}}, prefetch_data};
          else                  fields.disp[15:8] <= prefetch_data;
          byte_cnt <= disp_last ? 2'd0 : byte_cnt + 2'd1;
        end
        ST_IMM: begin
          fields.imm[{byte_cnt, 3'b000} +: 8] <= prefetch_data;
          byte_cnt <= imm_last ? 2'd0 : byte_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign opcode             = fields.opcode;
  assign has_modrm          = fields.has_modrm;
  assign modrm              = fields.modrm;
  assign disp               = fields.disp;
  assign disp_size          = fields.disp_size;
  assign imm                = fields.imm;
  assign imm_size           = fields.imm_size;
  assign seg_override_valid = fields.seg_override_valid;
  assign seg_override       = fields.seg_override;
  assign rep_prefix         = fields.rep_prefix;
  assign lock_prefix        = fields.lock_prefix;
  assign instr_length       = length;

endmodule

// File: tb/tb_instruction_collector.sv
// tb/tb_instruction_collector.sv - self-checking bench for instruction_collector
module tb_instruction_collector;

  typedef struct packed {
    logic [7:0]  opcode;
    logic        has_modrm;
    logic [7:0]  modrm;
    logic [15:0] disp;
    logic [1:0]  disp_size;
    logic [31:0] imm;
    logic [2:0]  imm_size;
    logic        segv;
    logic [1:0]  seg;
    logic [1:0]  rep;
    logic        lock;
    logic [3:0]  len;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [7:0]  prefetch_data;
  logic        queue_empty;
  logic        queue_pop;
  logic        flush;
  logic        instr_ready;
  logic        instr_valid;
  logic [7:0]  opcode;
  logic        has_modrm;
  logic [7:0]  modrm;
  logic [15:0] disp;
  logic [1:0]  disp_size;
  logic [31:0] imm;
  logic [2:0]  imm_size;
  logic        seg_override_valid;
  logic [1:0]  seg_override;
  logic [1:0]  rep_prefix;
  logic        lock_prefix;
  logic [3:0]  instr_length;

  int total = 0;
  int bad   = 0;

  logic [8:0] feed[$];   // bit 8 set = one cycle of empty queue
  logic [7:0] stim[$];
  exp_t       exp_q[$];
  exp_t       last;
  logic       pop_s;

  instruction_collector #(.LENGTH_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .prefetch_data(prefetch_data), .queue_empty(queue_empty),
    .queue_pop(queue_pop), .flush(flush), .instr_ready(instr_ready), .instr_valid(instr_valid),
    .opcode(opcode), .has_modrm(has_modrm), .modrm(modrm), .disp(disp), .disp_size(disp_size),
    .imm(imm), .imm_size(imm_size), .seg_override_valid(seg_override_valid),
    .seg_override(seg_override), .rep_prefix(rep_prefix), .lock_prefix(lock_prefix),
    .instr_length(instr_length)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic exp_t dut_fields();
    exp_t d;
    d = '{opcode, has_modrm, modrm, disp, disp_size, imm, imm_size,
          seg_override_valid, seg_override, rep_prefix, lock_prefix, instr_length};
    return d;
  endfunction

  // Instruction-set facts for the opcodes the bench uses.
  task automatic model_table(input logic [7:0] op, output int nm, output int isz);
    nm = 0; isz = 0;
    case (op)
      8'h8B, 8'hF6, 8'hF7: nm = 1;
      8'h80:               begin nm = 1; isz = 1; end
      8'hB0, 8'hCD:        isz = 1;
      8'hB8, 8'hC2:        isz = 2;
      8'hC8:               isz = 3;
      8'h9A:               isz = 4;
      default: ;
    endcase
  endtask

  // Walks the byte stream instruction by instruction and queues the expected results.
  task automatic model_stim();
    int i = 0;
    while (i < stim.size()) begin
      exp_t e;
      int start, nm, isz, dsz;
      e = '0; start = i; dsz = 0;
      while (stim[i] inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'hF0, 8'hF2, 8'hF3}) begin
        case (stim[i])
          8'h26: begin e.segv = 1; e.seg = 3; end
          8'h2E: begin e.segv = 1; e.seg = 0; end
          8'h36: begin e.segv = 1; e.seg = 1; end
          8'h3E: begin e.segv = 1; e.seg = 2; end
          8'hF0: e.lock = 1;
          8'hF2: e.rep = 2;
          default: e.rep = 3;
        endcase
        i++;
      end
      e.opcode = stim[i]; i++;
      model_table(e.opcode, nm, isz);
      if (nm != 0) begin
        e.has_modrm = 1;
        e.modrm = stim[i]; i++;
        if (e.modrm[7:6] == 2'b01) dsz = 1;
        else if (e.modrm[7:6] == 2'b10 || (e.modrm[7:6] == 2'b00 && e.modrm[2:0] == 3'b110)) dsz = 2;
        if (e.opcode == 8'hF6 && e.modrm[5:3] == 3'b000) isz = 1;
        if (e.opcode == 8'hF7 && e.modrm[5:3] == 3'b000) isz = 2;
        for (int k = 0; k < dsz; k++) begin e.disp[8*k +: 8] = stim[i]; i++; end
        if (dsz == 1) e.disp[15:8] = {8{e.disp[7]}};
        e.disp_size = 2'(dsz);
      end
      for (int k = 0; k < isz; k++) begin e.imm[8*k +: 8] = stim[i]; i++; end
      e.imm_size = 3'(isz);
      e.len = (i - start > 15) ? 4'd15 : 4'(i - start);
      exp_q.push_back(e);
    end
  endtask

  task automatic feed_stim();
    foreach (stim[k]) feed.push_back({1'b0, stim[k]});
  endtask

  task automatic send();
    model_stim();
    feed_stim();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((feed.size() != 0 || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check(name, (n < 300), 1);
  endtask

  // Queue driver: presents the head byte, removes it after the edge that popped it.
  initial begin
    queue_empty = 1'b1;
    prefetch_data = 8'h00;
    forever begin
      @(negedge clk);
      pop_s = queue_pop;
      @(posedge clk);
      #1;
      if (feed.size() > 0 && (feed[0][8] || pop_s)) void'(feed.pop_front());
      if (feed.size() == 0 || feed[0][8]) begin
        queue_empty = 1'b1;
        prefetch_data = 8'h00;
      end else begin
        queue_empty = 1'b0;
        prefetch_data = feed[0][7:0];
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!reset) begin
      if (queue_empty) begin
        total++;
        if (queue_pop !== 1'b0) begin bad++; $display("FAIL pop_while_empty: got %b want 0", queue_pop); end
      end
      if (instr_valid) begin
        total++;
        if (queue_pop !== 1'b0) begin bad++; $display("FAIL pop_while_valid: got %b want 0", queue_pop); end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_instr: got opcode %h want none", opcode);
        end else if (dut_fields() !== exp_q[0]) begin
          bad++;
          $display("FAIL fields: got %h want %h", dut_fields(), exp_q[0]);
        end
        if (instr_ready && !flush) begin
          last = dut_fields();
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  logic       pops[4], vals[4], mods[4];
  logic [7:0] ops[4];
  logic [3:0] lens[4];
  exp_t       snap;

  initial begin
    reset = 1'b1; flush = 1'b0; instr_ready = 1'b1;

    // Reset with a non-empty queue, then 90 / C3 back to back.
    stim = '{8'h90, 8'hC3};
    send();
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      check("reset_pop", queue_pop, 0);
      check("reset_valid", instr_valid, 0);
      check("reset_opcode", opcode, 0);
      check("reset_len", instr_length, 0);
      check("reset_seg", {seg_override_valid, rep_prefix, lock_prefix}, 0);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      pops[c] = queue_pop; vals[c] = instr_valid; ops[c] = opcode;
      lens[c] = instr_length; mods[c] = has_modrm;
    end
    check("c0_pop", pops[0], 1);
    check("c0_valid", vals[0], 0);
    check("c1_valid", vals[1], 1);
    check("c1_pop", pops[1], 0);
    check("c1_opcode", ops[1], 8'h90);
    check("c1_len", lens[1], 1);
    check("c1_has_modrm", mods[1], 0);
    check("c2_pop", pops[2], 1);
    check("c3_valid", vals[3], 1);
    check("c3_opcode", ops[3], 8'hC3);
    tick();
    wait_idle("idle_90_c3");

    stim = '{8'h2E, 8'h8B, 8'h86, 8'h34, 8'h12};
    send(); wait_idle("idle_seg_disp16");
    check("sd_segv", last.segv, 1);
    check("sd_seg", last.seg, 0);
    check("sd_opcode", last.opcode, 8'h8B);
    check("sd_modrm", last.modrm, 8'h86);
    check("sd_disp", last.disp, 16'h1234);
    check("sd_disp_size", last.disp_size, 2);
    check("sd_len", last.len, 5);

    stim = '{8'hF6, 8'hC0, 8'h55, 8'hF6, 8'hD0};
    model_stim(); feed_stim();
    wait_idle("idle_f6");
    check("f6_not_imm_size", last.imm_size, 0);
    check("f6_not_len", last.len, 2);

    stim = '{8'hF6, 8'hC0, 8'h55};
    send(); wait_idle("idle_f6_test");
    check("f6_test_imm", last.imm, 32'h55);
    check("f6_test_imm_size", last.imm_size, 1);
    check("f6_test_len", last.len, 3);

    // B8 with three empty cycles inside the immediate.
    stim = '{8'hB8, 8'h34, 8'h12};
    model_stim();
    feed.push_back(9'h0B8);
    repeat (3) feed.push_back(9'h100);
    feed.push_back(9'h034);
    feed.push_back(9'h012);
    wait_idle("idle_gap");
    check("gap_imm", last.imm, 32'h1234);
    check("gap_len", last.len, 3);

    stim = '{8'h8B, 8'h46, 8'hFE};
    send(); wait_idle("idle_disp8");
    check("disp8_sext", last.disp, 16'hFFFE);

    stim = '{8'hC8, 8'h10, 8'h00, 8'h01, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hC2, 8'h08, 8'h00, 8'h80, 8'h06, 8'h34, 8'h12, 8'h7F,
             8'hF2, 8'hF3, 8'hF0, 8'h26, 8'h36, 8'hA5, 8'hF1};
    send(); wait_idle("idle_mixed");
    check("last_undefined_op", last.opcode, 8'hF1);
    check("last_undefined_len", last.len, 1);

    stim = {};
    repeat (15) stim.push_back(8'h2E);
    stim.push_back(8'h90);
    send(); wait_idle("idle_saturate");
    check("len_saturate", last.len, 15);

    // Flush while collecting the displacement.
    stim = '{8'h2E, 8'h8B, 8'h86, 8'h34};
    feed_stim();
    begin
      int n = 0;
      while (feed.size() != 0 && n < 50) begin tick(); n++; end
      check("flush_setup", (n < 50), 1);
    end
    tick();
    flush = 1'b1;
    stim = '{8'h90};
    send();
    @(negedge clk);
    check("flush_no_pop", queue_pop, 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_no_valid", instr_valid, 0);
    wait_idle("idle_after_flush");
    check("flush_opcode", last.opcode, 8'h90);
    check("flush_segv", last.segv, 0);

    // Stall: instr_ready low while more bytes wait.
    tick();
    instr_ready = 1'b0;
    stim = '{8'hB0, 8'h7F, 8'h90};
    send();
    begin
      int n = 0;
      @(negedge clk);
      while (!instr_valid && n < 50) begin @(negedge clk); n++; end
      check("stall_reached", (n < 50), 1);
    end
    snap = dut_fields();
    check("stall_imm", snap.imm, 32'h7F);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_stable", (dut_fields() === snap), 1);
      check("stall_no_pop", queue_pop, 0);
      check("stall_valid", instr_valid, 1);
    end
    tick();
    instr_ready = 1'b1;
    wait_idle("idle_after_stall");
    check("stall_next_opcode", last.opcode, 8'h90);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_collector.md
Name: instruction_collector

Overview:
- Sits directly downstream of prefetch_queue and directly upstream of the execution unit.
- Pops instruction bytes one per cycle from the queue head and absorbs prefixes.
- Gathers opcode, ModRM, displacement and immediate fields.
- Presents one complete, field-split instruction to the execution unit with a valid/ready handshake.
- The execution unit consumes instructions, never raw bytes.

Parameters:
- LENGTH_WIDTH, 4: width of instr_length. Counts all bytes including prefixes; saturates at 2^LENGTH_WIDTH-1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- prefetch_data  input  8  byte at queue head; valid when queue_empty=0
- queue_empty  input  1  prefetch queue has no bytes
- queue_pop  output  1  combinational; consume head byte this cycle
- flush  input  1  branch/interrupt; discard partial or pending instruction
- instr_ready  input  1  execution unit accepts the instruction
- instr_valid  output  1  complete instruction on outputs
- opcode  output  8  opcode byte
- has_modrm  output  1  ModRM present
- modrm  output  8  ModRM byte, 0 if absent
- disp  output  16  displacement; an 8-bit displacement is sign-extended
- disp_size  output  2  0, 1 or 2 bytes
- imm  output  32  immediate, little-endian; unused bytes are 0
- imm_size  output  3  0 to 4 bytes
- seg_override_valid  output  1  segment prefix seen
- seg_override  output  2  0=PS, 1=SS, 2=DS0, 3=DS1 (matches segment register file index)
- rep_prefix  output  2  0 none, 2 REPNE (F2), 3 REP (F3)
- lock_prefix  output  1  F0 seen
- instr_length  output  LENGTH_WIDTH  total bytes consumed

Behaviour:
- Reset:
  - state=OPCODE.
  - All outputs 0, including instr_valid and queue_pop.
  - Prefix and field registers cleared.
- States: OPCODE, MODRM, DISP, IMM, DONE.
- queue_pop = (state in {OPCODE, MODRM, DISP, IMM}) && !queue_empty && !flush && !reset.
- A byte is captured at the clock edge on which queue_pop=1. While queue_empty=1 the FSM holds state and registers.
- OPCODE state:
  - Prefix bytes update the prefix registers, increment length, and stay in OPCODE.
    - 26 gives seg 3; 2E gives 0; 36 gives 1; 3E gives 2.
    - F0 sets lock_prefix; F2 and F3 set rep_prefix.
    - When a second prefix of the same kind arrives, the last one wins.
  - Any other byte latches opcode.
  - The next state comes from the classifier: MODRM if need_modrm, else IMM if imm_size>0, else DONE.
- MODRM state:
  - Latch modrm.
  - disp_size: mod=01 gives 1; mod=10 gives 2; mod=00 with rm=110 gives 2; otherwise 0.
  - imm_size is recomputed with modrm.reg so that F6/F7 with reg=000 carry imm8/imm16.
  - Next state is DISP, else IMM, else DONE.
- DISP and IMM states:
  - A byte counter indexes the field, least significant byte first.
  - Leave the state when counter = size-1.
  - Special immediate sizes: C8 ENTER has imm_size 3; 9A/EA have 4; C2/CA have 2.
- DONE state:
  - instr_valid=1 and all field outputs stable; no pops.
  - On instr_ready=1: go to OPCODE next cycle and clear all field and prefix registers.
- Latency: an N-byte instruction with the queue never empty gives N pop cycles, then instr_valid in cycle N+1. The next instruction's first pop comes the cycle after acceptance.
- instr_length increments on every pop and saturates.
- flush:
  - Next state is OPCODE; everything is cleared; instr_valid=0 the following cycle; no pop in the flush cycle.
  - If flush, instr_valid and instr_ready are all 1 in the same cycle, the instruction counts as accepted; the result is identical to flush alone.
- Reset mid-instruction: identical to flush, and all outputs go to reset values.
- Undefined opcodes are treated as 1-byte instructions without ModRM.

Decomposition:
- Shared package v30mz_pkg holds:
  - prefix byte constants;
  - segment index constants PS/SS/DS0/DS1;
  - the FSM state enum;
  - typedef instr_fields_t bundling the output fields.
- One sub-module, opcode_classifier: combinational.
  - Inputs: opcode, modrm_reg, modrm_valid.
  - Outputs: is_prefix, need_modrm, imm_size.
  - Holds the 256-entry opcode table.

Test Plan:
- Reset asserted 2 cycles with queue non-empty: queue_pop=0 throughout, all outputs 0. After release, first pop in the next cycle.
- Bytes 90 then C3 available continuously:
  - Pop in cycle 0; instr_valid in cycle 1 with opcode=90, length=1, has_modrm=0.
  - With instr_ready=1: C3 popped in cycle 2; valid in cycle 3.
- Stream 2E 8B 86 34 12:
  - 5 pops, then instr_valid with seg_override_valid=1, seg_override=0, opcode=8B, modrm=86, disp=1234, disp_size=2, length=5.
- F6 C0 55: imm=00000055, imm_size=1, length=3. Then F6 D0: imm_size=0, length=2.
- B8, then queue_empty held 3 cycles, then 34 12: no pops during the empty cycles; valid after the last pop with imm=00001234 and length=3. Also 8B 46 FE gives disp=FFFE.
- Two further cases:
  - flush asserted while in DISP for 8B 86 34: no instr_valid; the next stream 90 decodes cleanly with seg_override_valid=0.
  - instr_valid held with instr_ready=0 for 4 cycles: outputs stable and queue_pop=0.
